// File: rtl/gb_mapper_pkg.sv
// Shared types and constants for the MBC5-style cartridge bank mapper.
package gb_mapper_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE    = 2'd1,
    COMMIT    = 2'd2,
    WAIT_HIGH = 2'd3
  } wr_state_e;

  typedef enum logic [2:0] {
    RGN_RAMG,
    RGN_ROMB0,
    RGN_ROMB1,
    RGN_RAMB,
    RGN_NONE
  } region_e;

  // Cart_a[15:12] match values for the register windows
  localparam logic [3:0] RAMG_NIB_LO  = 4'h0;
  localparam logic [3:0] RAMG_NIB_HI  = 4'h1;
  localparam logic [3:0] ROMB0_NIB    = 4'h2;
  localparam logic [3:0] ROMB1_NIB    = 4'h3;
  localparam logic [3:0] RAMB_NIB_LO  = 4'h4;
  localparam logic [3:0] RAMB_NIB_HI  = 4'h5;
  localparam logic [2:0] SRAM_WINDOW  = 3'b101;

  localparam logic [3:0] RAMG_KEY = 4'hA;

  localparam int unsigned ROM_BANK_RESET = 1;
  localparam int unsigned RAM_BANK_RESET = 0;

  function automatic region_e decode_region(input logic [3:0] nib);
    case (nib)
      RAMG_NIB_LO, RAMG_NIB_HI: decode_region = RGN_RAMG;
      ROMB0_NIB:                decode_region = RGN_ROMB0;
      ROMB1_NIB:                decode_region = RGN_ROMB1;
      RAMB_NIB_LO, RAMB_NIB_HI: decode_region = RGN_RAMB;
      default:                  decode_region = RGN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gb_wr_strobe_sync.sv
// Synchronises and glitch-filters the asynchronous cartridge write strobe,
// producing exactly one commit pulse per accepted strobe.
module gb_wr_strobe_sync
  import gb_mapper_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic nwr,
  output logic commit_c
);

  localparam int unsigned MAX_CNT = (SETTLE_CYCLES > SYNC_STAGES) ? SETTLE_CYCLES : SYNC_STAGES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   nwr_sync;
  logic                   nwr_prev;
  logic                   fall;
  logic                   primed;
  logic [CNT_W-1:0]       cnt;
  wr_state_e              state;
  wr_state_e              state_next;

  assign nwr_sync = sync_q[SYNC_STAGES-1];
  assign fall     = nwr_prev & ~nwr_sync;

  // Synchroniser chain and edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '1;
      nwr_prev <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], nwr};
      nwr_prev <= nwr_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_HIGH;
    else     state <= state_next;
  end

  // After reset the chain is preset high, so a strobe held low across reset
  // must be seen high for a full chain's worth of samples before re-arming.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (fall) state_next = SETTLE;
      SETTLE: begin
        if (nwr_sync)                            state_next = IDLE;
        else if (cnt == CNT_W'(SETTLE_CYCLES))   state_next = COMMIT;
      end
      COMMIT:    state_next = WAIT_HIGH;
      WAIT_HIGH: if (nwr_sync && (primed || cnt == CNT_W'(SYNC_STAGES))) state_next = IDLE;
      default:   state_next = WAIT_HIGH;
    endcase
  end

  always_comb begin
    commit_c = 1'b0;
    if (state == COMMIT) commit_c = 1'b1;
  end

  // Settle counter doubles as the post-reset high-sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      primed <= 1'b0;
    end else begin
      case (state)
        IDLE:      cnt <= CNT_W'(1);
        SETTLE:    cnt <= cnt + CNT_W'(1);
        COMMIT:    cnt <= '0;
        WAIT_HIGH: cnt <= nwr_sync ? cnt + CNT_W'(1) : '0;
        default:   cnt <= '0;
      endcase
      if (state == WAIT_HIGH && state_next == IDLE) primed <= 1'b1;
    end
  end

endmodule

// File: rtl/gb_mbc5_mapper.sv
// Game Boy MBC5-style bank mapper: register decode on committed writes and a
// zero-latency banked address mux for cartridge ROM and SRAM.
module gb_mbc5_mapper
  import gb_mapper_pkg::*;
#(
  parameter int unsigned ROM_BANK_BITS   = 9,
  parameter int unsigned RAM_BANK_BITS   = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned SETTLE_CYCLES   = 3,
  parameter int unsigned ZERO_BANK_REMAP = 0,
  localparam int unsigned RAM_A_W = (RAM_BANK_BITS > 0) ? RAM_BANK_BITS : 1
) (
  input  logic                     sys_clock,
  input  logic                     sys_reset,
  input  logic [15:0]              Cart_a,
  input  logic [7:0]               Cart_d_in,
  input  logic                     Cart_nWR,
  output logic [ROM_BANK_BITS-1:0] Rom_a,
  output logic                     Rom_nCS,
  output logic [RAM_A_W-1:0]       Ram_a,
  output logic                     Ram_nCS,
  output logic                     ram_enabled,
  output logic                     reg_write
);

  localparam int unsigned LO_W = (ROM_BANK_BITS < 8) ? ROM_BANK_BITS : 8;

  logic [ROM_BANK_BITS-1:0] rom_bank;
  logic [RAM_A_W-1:0]       ram_bank;
  logic                     ram_en;
  logic                     commit_c;
  logic [LO_W-1:0]          romb0_val;
  logic [8:0]               rom_next;
  logic [3:0]               ram_next;
  logic                     ram_en_next;
  logic                     unused_addr;

  assign unused_addr = ^Cart_a[11:0];

  gb_wr_strobe_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_wr_sync (
    .clk     (sys_clock),
    .rst     (sys_reset),
    .nwr     (Cart_nWR),
    .commit_c(commit_c)
  );

  // Remap is applied after truncation to the implemented bank width
  always_comb begin
    romb0_val = Cart_d_in[LO_W-1:0];
    if (ZERO_BANK_REMAP != 0 && romb0_val == '0) romb0_val = LO_W'(1);
  end

  // Widen to the full MBC5 register so narrower builds simply drop upper bits
  always_comb begin
    rom_next    = 9'(rom_bank);
    ram_next    = 4'(ram_bank);
    ram_en_next = ram_en;
    case (decode_region(Cart_a[15:12]))
      RGN_RAMG:  ram_en_next   = (Cart_d_in[3:0] == RAMG_KEY);
      RGN_ROMB0: rom_next[7:0] = 8'(romb0_val);
      RGN_ROMB1: rom_next[8]   = Cart_d_in[0];
      RGN_RAMB:  ram_next      = Cart_d_in[3:0];
      default:   ;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      rom_bank  <= ROM_BANK_BITS'(ROM_BANK_RESET);
      ram_bank  <= RAM_A_W'(RAM_BANK_RESET);
      ram_en    <= 1'b0;
      reg_write <= 1'b0;
    end else begin
      reg_write <= commit_c;
      if (commit_c) begin
        rom_bank <= rom_next[ROM_BANK_BITS-1:0];
        ram_bank <= (RAM_BANK_BITS == 0) ? '0 : ram_next[RAM_A_W-1:0];
        ram_en   <= ram_en_next;
      end
    end
  end

  assign ram_enabled = ram_en;
  assign Rom_nCS     = Cart_a[15];
  assign Rom_a       = (Cart_a[15:14] == 2'b00) ? '0 : rom_bank;
  assign Ram_nCS     = !(ram_en && Cart_a[15:13] == SRAM_WINDOW);
  assign Ram_a       = ram_bank;

endmodule
